// File: rtl/fault_latch_bank.sv
// Sticky fault latch bank: per-channel debounce of active-low health inputs,
// first-fault capture, a saturating latch-event counter and a maskable alarm.
module fault_latch_bank #(
  parameter int N_CH     = 8,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8,
  localparam int IDW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  in,
  input  logic [N_CH-1:0]  mask,
  input  logic             clear,
  input  logic             LA_Test,
  output logic [N_CH-1:0]  out,
  output logic             LA,
  output logic             first_valid,
  output logic [IDW-1:0]   first_id,
  output logic [CNT_W-1:0] fault_cnt
);

  // The count only ever holds 0..DEBOUNCE-1; the DEBOUNCE-th low sample latches.
  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  logic [DBW-1:0]  db_cnt [N_CH];
  logic [N_CH-1:0] qual;
  logic [N_CH-1:0] done;
  logic [IDW-1:0]  new_idx;

  // NOTE: every combinational output gets a default before any conditional
  // assignment so no latch is inferred.
  always_comb begin
    qual    = '0;
    done    = '0;
    new_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      qual[i] = !in[i] && !mask[i] && !out[i];
      done[i] = qual[i] && (db_cnt[i] == DB_LAST);
    end
    // Walk from the top so the lowest newly-set index wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (done[i]) new_idx = IDW'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out         <= '0;
      first_valid <= 1'b0;
      first_id    <= '0;
      fault_cnt   <= '0;
      // NOTE: the debounce counters are a small flop array, not RAM, so they
      // can and must be reset; a RAM-backed array could not be cleared this way.
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else if (clear) begin
      out         <= '0;
      first_valid <= 1'b0;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else begin
      out <= out | done;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt[i] <= (qual[i] && !done[i]) ? db_cnt[i] + 1'b1 : '0;
      end
      if (|done) begin
        if (!first_valid) begin
          first_valid <= 1'b1;
          first_id    <= new_idx;
        end
        if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
      end
    end
  end

  assign LA = (|(out & ~mask)) | LA_Test;

endmodule

// File: tb/tb_fault_latch_bank.sv
// Directed bench for fault_latch_bank: two instances (DEBOUNCE=3/CNT_W=8 and
// DEBOUNCE=1/CNT_W=2) share stimulus and are checked against a run-length model.
module tb_fault_latch_bank;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset, clear, la_test;
  logic [N-1:0] in_v, mask_v;

  logic [N-1:0] out_a, out_b;
  logic         la_a, la_b, fv_a, fv_b;
  logic [2:0]   fid_a, fid_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fault_latch_bank #(.N_CH(N), .DEBOUNCE(3), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in(in_v), .mask(mask_v), .clear(clear),
    .LA_Test(la_test), .out(out_a), .LA(la_a), .first_valid(fv_a),
    .first_id(fid_a), .fault_cnt(cnt_a)
  );

  fault_latch_bank #(.N_CH(N), .DEBOUNCE(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in(in_v), .mask(mask_v), .clear(clear),
    .LA_Test(la_test), .out(out_b), .LA(la_b), .first_valid(fv_b),
    .first_id(fid_b), .fault_cnt(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per instance, count consecutive qualifying low samples per channel.
  int           db   [2] = '{3, 1};
  int           cmax [2] = '{255, 3};
  int           run  [2][N];
  logic [N-1:0] m_out [2];
  bit           m_fv  [2];
  int           m_fid [2];
  int           m_cnt [2];
  bit           armed = 0;

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_out[m] = '0; m_fv[m] = 0; m_fid[m] = 0; m_cnt[m] = 0;
        for (int i = 0; i < N; i++) run[m][i] = 0;
      end else if (clear) begin
        m_out[m] = '0; m_fv[m] = 0;
        for (int i = 0; i < N; i++) run[m][i] = 0;
      end else begin
        logic [N-1:0] newly;
        newly = '0;
        for (int i = 0; i < N; i++) begin
          if (!in_v[i] && !mask_v[i] && !m_out[m][i]) run[m][i]++;
          else run[m][i] = 0;
          if (run[m][i] == db[m]) begin
            newly[i] = 1'b1;
            run[m][i] = 0;
          end
        end
        if (newly != 0) begin
          m_out[m] = m_out[m] | newly;
          if (m_cnt[m] < cmax[m]) m_cnt[m]++;
          if (!m_fv[m]) begin
            m_fv[m] = 1;
            for (int i = N - 1; i >= 0; i--) if (newly[i]) m_fid[m] = i;
          end
        end
      end
    end
    if (reset) armed = 1;
  end

  function automatic logic model_la(input int m);
    return (|(m_out[m] & ~mask_v)) | la_test;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      check("a_out", out_a, m_out[0]);
      check("a_la",  la_a,  model_la(0));
      check("a_fv",  fv_a,  m_fv[0]);
      check("a_fid", fid_a, m_fid[0]);
      check("a_cnt", cnt_a, m_cnt[0]);
      check("b_out", out_b, m_out[1]);
      check("b_la",  la_b,  model_la(1));
      check("b_fv",  fv_b,  m_fv[1]);
      check("b_fid", fid_b, m_fid[1]);
      check("b_cnt", cnt_b, m_cnt[1]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(1); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; la_test = 1'b0; in_v = '1; mask_v = '0;
    step(2);
    check("rst_out", out_a, 8'h00);
    check("rst_cnt", cnt_a, 8'd0);
    check("rst_la", la_a, 1'b0);
    la_test = 1'b1; #1;
    check("rst_la_test", la_a, 1'b1);
    la_test = 1'b0;
    step(1);
    reset = 1'b0;

    // Debounce with a restart: low 2, high 1, low 3 on channel 2.
    in_v = 8'hFB; step(2);
    in_v = 8'hFF; step(1);
    in_v = 8'hFB; step(2);
    check("db_not_yet", out_a, 8'h00);
    check("db1_latched", out_b, 8'h04);
    step(1);
    check("db_out", out_a, 8'h04);
    check("db_la", la_a, 1'b1);
    check("db_fid", fid_a, 3'd2);
    check("db_cnt", cnt_a, 8'd1);
    in_v = 8'hFF; do_reset();

    // Channels 1 and 5 complete on the same edge.
    in_v = 8'hDD; step(3);
    check("sim_out", out_a, 8'h22);
    check("sim_fid", fid_a, 3'd1);
    check("sim_cnt", cnt_a, 8'd1);
    in_v = 8'hFF; do_reset();

    // Sticky and mask on channel 4, then lamp test without a clock edge.
    in_v = 8'hEF; step(3);
    check("stk_out", out_a, 8'h10);
    in_v = 8'hFF; mask_v = 8'h10; step(1);
    check("stk_hold", out_a, 8'h10);
    check("stk_la_masked", la_a, 1'b0);
    la_test = 1'b1; #1;
    check("stk_la_test", la_a, 1'b1);
    la_test = 1'b0; mask_v = '0; #1;

    // Clear races channel 0 completing; counter and first_id survive clear.
    in_v = 8'hFE; step(2);
    clear = 1'b1; step(1);
    check("clr_out", out_a, 8'h00);
    check("clr_fv", fv_a, 1'b0);
    check("clr_fid", fid_a, 3'd4);
    check("clr_cnt", cnt_a, 8'd1);
    clear = 1'b0; step(2);
    check("clr_relatch_early", out_a, 8'h00);
    step(1);
    check("clr_relatch", out_a, 8'h01);
    check("clr_new_fid", fid_a, 3'd0);
    check("clr_new_cnt", cnt_a, 8'd2);
    in_v = 8'hFF; do_reset();

    // Reset with clear after two low samples; needs three fresh samples.
    in_v = 8'hF7; step(2);
    reset = 1'b1; clear = 1'b1; step(1);
    check("mid_rst_out", out_a, 8'h00);
    check("mid_rst_cnt", cnt_a, 8'd0);
    reset = 1'b0; clear = 1'b0; step(2);
    check("mid_rst_early", out_a, 8'h00);
    step(1);
    check("mid_rst_out2", out_a, 8'h08);
    check("mid_rst_cnt2", cnt_a, 8'd1);

    // Five separate latch events: 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      in_v = ~(8'(1) << k); step(3);
      in_v = 8'hFF; clear = 1'b1; step(1);
      clear = 1'b0;
    end
    check("sat_b_cnt", cnt_b, 2'd3);
    check("sat_a_cnt", cnt_a, 8'd6);

    // A masked sample in the middle restarts channel 6's debounce.
    in_v = 8'hBF; step(2);
    mask_v = 8'h40; step(1);
    mask_v = 8'h00; step(2);
    check("mask_restart", out_a, 8'h00);
    step(1);
    check("mask_latched", out_a, 8'h40);
    check("mask_cnt", cnt_a, 8'd7);
    in_v = 8'hFF; step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fault_latch_bank.md
FAULT_LATCH_BANK -- requirements
Module: fault_latch_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, meaning number of monitored fault channels (legal range 1..32).
REQ-002 The block SHALL have parameter DEBOUNCE, default 3, meaning consecutive low samples needed to latch a channel (legal range 1..255).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning width of the latch-event counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in, input, N_CH bits: per-channel health; 1 = healthy, 0 = fault.
REQ-007 The block SHALL have port mask, input, N_CH bits: 1 = channel ignored for new latching and for LA.
REQ-008 The block SHALL have port clear, input, 1 bit: level-sampled request to clear latched faults.
REQ-009 The block SHALL have port LA_Test, input, 1 bit: lamp test that forces LA high.
REQ-010 The block SHALL have port out, output, N_CH bits: sticky latched fault flags.
REQ-011 The block SHALL have port LA, output, 1 bit: alarm, equal to OR of (out AND NOT mask) OR LA_Test (combinational).
REQ-012 The block SHALL have port first_valid, output, 1 bit: first-fault record valid.
REQ-013 The block SHALL have port first_id, output, IDW bits (IDW = max(1, clog2(N_CH))): index of first channel latched.
REQ-014 The block SHALL have port fault_cnt, output, CNT_W bits: number of edges on which at least one channel newly latched.

Function
REQ-015 Each channel SHALL keep a debounce count that increments when in[i]=0, mask[i]=0 and out[i]=0, and resets to 0 otherwise.
REQ-016 out[i] SHALL set at the edge where the DEBOUNCE-th consecutive qualifying low sample is taken: lows sampled at edges k..k+DEBOUNCE-1 give out[i]=1 after edge k+DEBOUNCE-1.
REQ-017 With DEBOUNCE=1, out[i] SHALL set after the first edge that samples in[i]=0 unmasked.
REQ-018 Any high sample, or mask[i]=1, before the count completes SHALL restart that channel's debounce from zero.
REQ-019 Once set, out[i] SHALL hold 1 regardless of in[i] or mask[i] until reset or clear.
REQ-020 Asserting mask[i] on an already-latched channel SHALL leave out[i]=1 and remove only its contribution to LA.
REQ-021 On an edge with clear=1 (and reset=0), out, all debounce counts and first_valid SHALL go to 0; clear SHALL win over a channel completing debounce on the same edge.
REQ-022 After clear deasserts, a still-present unmasked fault SHALL re-latch after a full DEBOUNCE-sample count.
REQ-023 clear SHALL NOT modify fault_cnt or first_id.
REQ-024 On an edge where first_valid=0 and one or more channels newly set, first_valid SHALL go to 1 and first_id SHALL load the lowest newly-set index.
REQ-025 While first_valid=1, first_id SHALL not change.
REQ-026 fault_cnt SHALL increment by exactly 1 on each edge where at least one channel newly sets, independent of how many channels set.
REQ-027 fault_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-028 LA SHALL respond to LA_Test and mask combinationally, with no added cycle of latency.

Reset
REQ-029 On an edge with reset=1, out, all debounce counts, first_valid, first_id and fault_cnt SHALL go to 0.
REQ-030 reset SHALL take priority over clear and over any channel completing debounce on the same edge.
REQ-031 LA SHALL equal LA_Test while out is all zero, including during reset.

Verification
REQ-032 Debounce: DEBOUNCE=3, in[2] low for 2 edges, high 1 edge, low 3 edges -> out[2] stays 0, then sets after the 3rd low edge; LA=1, first_id=2, fault_cnt=1.
REQ-033 Simultaneous: in[5] and in[1] reach their 3rd low sample on the same edge -> out=0x22, first_id=1, fault_cnt=1.
REQ-034 Sticky/mask: after out[4]=1, in[4] returns high and mask[4]=1 -> out[4] stays 1, LA=0; LA_Test=1 -> LA=1 in the same cycle.
REQ-035 Clear race: clear=1 on the edge where ch0 completes debounce -> out[0]=0, first_valid=0; with fault held, out[0] sets 3 edges after clear drops; fault_cnt is unchanged by clear.
REQ-036 Saturation: CNT_W=2, force 5 separate latch events -> fault_cnt=3.
REQ-037 Reset mid-debounce: reset asserted with clear=1 after 2 low samples -> all outputs 0; a fault present after reset deasserts needs 3 fresh low samples to latch.
